// File: rtl/memory_game_pkg.sv
// Shared types and constants for the card-matching game engine.
// Card faces, FSM states and the shuffle LFSR definition.
package memory_game_pkg;

  typedef enum logic [1:0] {
    FACE_DOWN = 2'd0,
    FACE_UP   = 2'd1,
    MATCHED   = 2'd2
  } card_state_t;

  typedef enum logic [2:0] {
    SHUFFLE,
    NONE_UP,
    ONE_UP,
    COMPARE,
    SHOW_MISMATCH,
    WIN
  } game_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/memory_game_core_button_conditioner.sv
// Active-low button: 2-flop synchroniser, falling-edge pulse and
// optional auto-repeat while the button stays held.
module button_conditioner #(
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_TICKS = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  logic          s1_q, s2_q, edge_q;
  logic [RW-1:0] rep_q, rep_d;
  logic          fall, held, rep_fire;

  assign fall     = edge_q & ~s2_q;
  assign held     = ~edge_q & ~s2_q;
  assign rep_fire = REPEAT_EN && held && (rep_q == '0);
  assign press_o  = fall | rep_fire;

  // Counter is reloaded by every pulse so repeats are REPEAT_TICKS apart.
  always_comb begin
    rep_d = rep_q;
    if (fall || rep_fire) begin
      rep_d = RW'(REPEAT_TICKS - 1);
    end else if (held) begin
      rep_d = rep_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      edge_q <= 1'b1;
      rep_q  <= '0;
    end else begin
      s1_q   <= btn_n_i;
      s2_q   <= s1_q;
      edge_q <= s2_q;
      rep_q  <= rep_d;
    end
  end

endmodule

// File: rtl/memory_game_core.sv
// Card-matching game engine: shuffle, cursor, flip/compare sequencing
// and score counters, with a combinational card query port.
module memory_game_core
  import memory_game_pkg::*;
#(
  parameter int COLS           = 5,
  parameter int ROWS           = 4,
  parameter int REPEAT_TICKS   = 12_500_000,
  parameter int MISMATCH_TICKS = 50_000_000,
  parameter int MOVE_W         = 10,
  localparam int N      = COLS * ROWS,
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1,
  localparam int PAIR_W = (N > 2) ? $clog2(N / 2) : 1,
  localparam int PF_W   = $clog2(N / 2) + 1
) (
  input  logic              clock_50M,
  input  logic              reset,
  input  logic              select,
  input  logic              move_x,
  input  logic              move_y,
  input  logic [IDX_W-1:0]  query_idx,
  output logic [1:0]        query_state,
  output logic [PAIR_W-1:0] query_pair,
  output logic [IDX_W-1:0]  cursor_idx,
  output logic [MOVE_W-1:0] moves,
  output logic [PF_W-1:0]   pairs_found,
  output logic              game_over,
  output logic              busy
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = (MISMATCH_TICKS > 1) ? $clog2(MISMATCH_TICKS) : 1;

  game_state_t       state_q, state_d;
  card_state_t       card_q [N];
  card_state_t       card_d [N];
  logic [PAIR_W-1:0] pair_q [N];
  logic [PAIR_W-1:0] pair_d [N];
  logic [15:0]       lfsr_q;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  first_q, first_d;
  logic [IDX_W-1:0]  second_q, second_d;
  logic [IDX_W-1:0]  k;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic [PF_W-1:0]   pf_q, pf_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              sel_p, mx_p, my_p, sel_ok;

  button_conditioner #(.REPEAT_EN(1'b0), .REPEAT_TICKS(2)) u_sel (
    .clk_i(clock_50M), .rst_i(reset), .btn_n_i(select), .press_o(sel_p)
  );
  button_conditioner #(.REPEAT_EN(1'b1), .REPEAT_TICKS(REPEAT_TICKS)) u_mx (
    .clk_i(clock_50M), .rst_i(reset), .btn_n_i(move_x), .press_o(mx_p)
  );
  button_conditioner #(.REPEAT_EN(1'b1), .REPEAT_TICKS(REPEAT_TICKS)) u_my (
    .clk_i(clock_50M), .rst_i(reset), .btn_n_i(move_y), .press_o(my_p)
  );

  assign cursor_idx  = IDX_W'(int'(row_q) * COLS + int'(col_q));
  assign k           = IDX_W'((16'(lfsr_q[7:0]) * (16'(i_q) + 16'd1)) >> 8);
  assign sel_ok      = sel_p && (card_q[cursor_idx] == FACE_DOWN);
  assign query_state = (int'(query_idx) < N) ? card_q[query_idx] : FACE_DOWN;
  assign query_pair  = (int'(query_idx) < N) ? pair_q[query_idx] : '0;
  assign moves       = moves_q;
  assign pairs_found = pf_q;
  assign game_over   = (state_q == WIN);
  assign busy        = (state_q == SHUFFLE) || (state_q == SHOW_MISMATCH);

  always_comb begin
    state_d  = state_q;
    card_d   = card_q;
    pair_d   = pair_q;
    col_d    = col_q;
    row_d    = row_q;
    i_d      = i_q;
    first_d  = first_q;
    second_d = second_q;
    moves_d  = moves_q;
    pf_d     = pf_q;
    timer_d  = timer_q;
    if (mx_p) col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    if (my_p) row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    unique case (state_q)
      SHUFFLE: begin
        pair_d[i_q] = pair_q[k];
        pair_d[k]   = pair_q[i_q];
        i_d         = i_q - 1'b1;
        if (i_q == IDX_W'(1)) state_d = NONE_UP;
      end
      NONE_UP: begin
        if (sel_ok) begin
          card_d[cursor_idx] = FACE_UP;
          first_d            = cursor_idx;
          state_d            = ONE_UP;
        end
      end
      ONE_UP: begin
        if (sel_ok) begin
          card_d[cursor_idx] = FACE_UP;
          second_d           = cursor_idx;
          if (moves_q != '1) moves_d = moves_q + 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (pair_q[first_q] == pair_q[second_q]) begin
          card_d[first_q]  = MATCHED;
          card_d[second_q] = MATCHED;
          pf_d             = pf_q + 1'b1;
          state_d = (pf_d == PF_W'(N / 2)) ? WIN : NONE_UP;
        end else begin
          timer_d = TW'(MISMATCH_TICKS - 1);
          state_d = SHOW_MISMATCH;
        end
      end
      SHOW_MISMATCH: begin
        if (timer_q == '0) begin
          card_d[first_q]  = FACE_DOWN;
          card_d[second_q] = FACE_DOWN;
          state_d          = NONE_UP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WIN: begin
        // Restart in place; the LFSR keeps running for a fresh order.
        if (sel_p) begin
          moves_d = '0;
          pf_d    = '0;
          i_d     = IDX_W'(N - 1);
          for (int j = 0; j < N; j++) begin
            card_d[j] = FACE_DOWN;
            pair_d[j] = PAIR_W'(j >> 1);
          end
          state_d = SHUFFLE;
        end
      end
      default: state_d = SHUFFLE;
    endcase
  end

  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      state_q <= SHUFFLE;
      for (int j = 0; j < N; j++) begin
        card_q[j] <= FACE_DOWN;
        pair_q[j] <= PAIR_W'(j >> 1);
      end
      lfsr_q   <= LFSR_SEED;
      col_q    <= '0;
      row_q    <= '0;
      i_q      <= IDX_W'(N - 1);
      first_q  <= '0;
      second_q <= '0;
      moves_q  <= '0;
      pf_q     <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      card_q   <= card_d;
      pair_q   <= pair_d;
      lfsr_q   <= lfsr_next(lfsr_q);
      col_q    <= col_d;
      row_q    <= row_d;
      i_q      <= i_d;
      first_q  <= first_d;
      second_q <= second_d;
      moves_q  <= moves_d;
      pf_q     <= pf_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_memory_game_core.sv
// Directed bench for memory_game_core: a 5x4 board and a 2x2 board
// share one clock; shuffles are checked against a reference model.
module tb_memory_game_core;

  localparam int RT = 8;
  localparam int MT = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, sel_a, mx_a, my_a;
  logic [4:0] qidx_a, cur_a;
  logic [1:0] qst_a;
  logic [3:0] qpr_a;
  logic [9:0] mv_a;
  logic [4:0] pf_a;
  logic       go_a, busy_a;

  logic       rst_b, sel_b, mx_b, my_b;
  logic [1:0] qidx_b, cur_b;
  logic [1:0] qst_b;
  logic [0:0] qpr_b;
  logic [9:0] mv_b;
  logic [1:0] pf_b;
  logic       go_b, busy_b;

  memory_game_core #(
    .COLS(5), .ROWS(4), .REPEAT_TICKS(RT),
    .MISMATCH_TICKS(MT), .MOVE_W(10)
  ) dut_a (
    .clock_50M(clk), .reset(rst_a), .select(sel_a),
    .move_x(mx_a), .move_y(my_a), .query_idx(qidx_a),
    .query_state(qst_a), .query_pair(qpr_a),
    .cursor_idx(cur_a), .moves(mv_a), .pairs_found(pf_a),
    .game_over(go_a), .busy(busy_a)
  );

  memory_game_core #(
    .COLS(2), .ROWS(2), .REPEAT_TICKS(RT),
    .MISMATCH_TICKS(MT), .MOVE_W(10)
  ) dut_b (
    .clock_50M(clk), .reset(rst_b), .select(sel_b),
    .move_x(mx_b), .move_y(my_b), .query_idx(qidx_b),
    .query_state(qst_b), .query_pair(qpr_b),
    .cursor_idx(cur_b), .moves(mv_b), .pairs_found(pf_b),
    .game_over(go_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cur_exp [2];
  int exp_pair [2][64];
  int prev_pair [64];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic [15:0] lm_a, lm_b;
  always @(posedge clk or posedge rst_a)
    if (rst_a) lm_a <= 16'hACE1;
    else       lm_a <= lfsr_step(lm_a);
  always @(posedge clk or posedge rst_b)
    if (rst_b) lm_b <= 16'hACE1;
    else       lm_b <= lfsr_step(lm_b);

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ncards(input int d);
    return (d == 0) ? 20 : 4;
  endfunction

  task automatic query(input int d, input int idx,
                       output int st, output int pr);
    if (d == 0) qidx_a = 5'(idx);
    else        qidx_b = 2'(idx);
    #1;
    if (d == 0) begin st = int'(qst_a); pr = int'(qpr_a); end
    else        begin st = int'(qst_b); pr = int'(qpr_b); end
  endtask

  task automatic outs(input int d, output int cur, output int mv,
                      output int pf, output int go, output int bz);
    if (d == 0) begin
      cur = int'(cur_a); mv = int'(mv_a); pf = int'(pf_a);
      go = int'(go_a); bz = int'(busy_a);
    end else begin
      cur = int'(cur_b); mv = int'(mv_b); pf = int'(pf_b);
      go = int'(go_b); bz = int'(busy_b);
    end
  endtask

  // b: 0 = select, 1 = move_x, 2 = move_y
  task automatic set_btn(input int d, input int b, input logic v);
    if (d == 0) begin
      if (b == 0) sel_a = v; else if (b == 1) mx_a = v; else my_a = v;
    end else begin
      if (b == 0) sel_b = v; else if (b == 1) mx_b = v; else my_b = v;
    end
  endtask

  task automatic press(input int d, input int b);
    @(negedge clk);
    set_btn(d, b, 1'b0);
    repeat (3) @(negedge clk);
    set_btn(d, b, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic goto(input int d, input int target);
    int cols, rows, r, c, cur, mv, pf, go, bz;
    cols = (d == 0) ? 5 : 2;
    rows = (d == 0) ? 4 : 2;
    while (cur_exp[d] / cols != target / cols) begin
      press(d, 2);
      r = (cur_exp[d] / cols + 1) % rows;
      cur_exp[d] = r * cols + cur_exp[d] % cols;
    end
    while (cur_exp[d] % cols != target % cols) begin
      press(d, 1);
      c = (cur_exp[d] % cols + 1) % cols;
      cur_exp[d] = (cur_exp[d] / cols) * cols + c;
    end
    outs(d, cur, mv, pf, go, bz);
    chk("goto cursor", cur, target);
  endtask

  task automatic model_shuffle(input int d, input logic [15:0] seed);
    int n, k, t;
    logic [15:0] l;
    n = ncards(d);
    l = seed;
    for (int j = 0; j < n; j++) exp_pair[d][j] = j >> 1;
    for (int i = n - 1; i >= 1; i--) begin
      k = (int'(l[7:0]) * (i + 1)) >> 8;
      t = exp_pair[d][i];
      exp_pair[d][i] = exp_pair[d][k];
      exp_pair[d][k] = t;
      l = lfsr_step(l);
    end
  endtask

  task automatic check_shuffle(input int d);
    int n, st, pr;
    int cnt [32];
    n = ncards(d);
    for (int p = 0; p < 32; p++) cnt[p] = 0;
    for (int j = 0; j < n; j++) begin
      query(d, j, st, pr);
      chk("shuffle pair", pr, exp_pair[d][j]);
      if (pr < 32) cnt[pr]++;
    end
    for (int p = 0; p < n / 2; p++) chk("pair occurrences", cnt[p], 2);
  endtask

  task automatic reset_dut(input int d);
    int n, cur, mv, pf, go, bz, st, pr, nfu, npb, cnt;
    n = ncards(d);
    @(negedge clk);
    if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
    for (int b = 0; b < 3; b++) set_btn(d, b, 1'b1);
    repeat (2) @(negedge clk);
    outs(d, cur, mv, pf, go, bz);
    chk("reset cursor", cur, 0);
    chk("reset moves", mv, 0);
    chk("reset pairs_found", pf, 0);
    chk("reset game_over", go, 0);
    chk("reset busy", bz, 1);
    nfu = 0;
    npb = 0;
    for (int j = 0; j < n; j++) begin
      query(d, j, st, pr);
      if (st != 0) nfu++;
      if (pr != (j >> 1)) npb++;
    end
    chk("reset cards not face-down", nfu, 0);
    chk("reset pair ids wrong", npb, 0);
    @(negedge clk);
    if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
    cnt = 0;
    outs(d, cur, mv, pf, go, bz);
    while (bz == 1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      outs(d, cur, mv, pf, go, bz);
    end
    chk("shuffle busy cycles", cnt, n - 1);
    cur_exp[d] = 0;
    model_shuffle(d, 16'hACE1);
    check_shuffle(d);
  endtask

  task automatic play_win(input int d, input int exp_moves);
    int n, i1, i2, cur, mv, pf, go, bz;
    n = ncards(d);
    for (int p = 0; p < n / 2; p++) begin
      i1 = -1;
      i2 = -1;
      for (int j = 0; j < n; j++)
        if (exp_pair[d][j] == p) begin
          if (i1 < 0) i1 = j; else i2 = j;
        end
      if (i1 >= 0 && i2 >= 0) begin
        goto(d, i1);
        press(d, 0);
        goto(d, i2);
        press(d, 0);
      end
    end
    outs(d, cur, mv, pf, go, bz);
    chk("win game_over", go, 1);
    chk("win pairs_found", pf, n / 2);
    chk("win moves", mv, exp_moves);
    chk("win busy", bz, 0);
  endtask

  task automatic restart(input int d);
    int n, cur, mv, pf, go, bz, seen, nb, ndiff;
    logic [15:0] seed;
    n = ncards(d);
    seen = 0;
    nb = 0;
    seed = 16'h0;
    @(negedge clk);
    set_btn(d, 0, 1'b0);
    for (int it = 1; it <= 40; it++) begin
      @(negedge clk);
      if (it == 3) set_btn(d, 0, 1'b1);
      outs(d, cur, mv, pf, go, bz);
      if (bz == 1) begin
        if (seen == 0) begin
          seen = 1;
          seed = (d == 0) ? lm_a : lm_b;
          chk("restart moves", mv, 0);
          chk("restart pairs_found", pf, 0);
          chk("restart game_over", go, 0);
        end
        nb++;
      end
    end
    chk("restart busy seen", seen, 1);
    chk("restart busy cycles", nb, n - 1);
    for (int j = 0; j < n; j++) prev_pair[j] = exp_pair[d][j];
    model_shuffle(d, seed);
    check_shuffle(d);
    if (d == 0) begin
      ndiff = 0;
      for (int j = 0; j < n; j++)
        if (prev_pair[j] != exp_pair[d][j]) ndiff++;
      chk("restart order differs", int'(ndiff > 0), 1);
    end
  endtask

  typedef struct {
    int btn;
    int exp_cur;
  } vec_t;

  initial begin
    #900_000;
    $display("FAIL timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [15];
    int cur, mv, pf, go, bz, st, pr;
    int a, b, c, d, e, nup, done, nfu;

    rst_a = 1'b1; rst_b = 1'b1;
    sel_a = 1'b1; mx_a = 1'b1; my_a = 1'b1; qidx_a = '0;
    sel_b = 1'b1; mx_b = 1'b1; my_b = 1'b1; qidx_b = '0;
    cur_exp[0] = 0;
    cur_exp[1] = 0;
    repeat (3) @(negedge clk);

    reset_dut(0);

    vt = '{'{1, 1}, '{1, 2}, '{1, 3}, '{1, 4}, '{1, 0},
           '{2, 5}, '{1, 6}, '{1, 7}, '{2, 12}, '{2, 17},
           '{2, 2}, '{1, 3}, '{1, 4}, '{1, 0}, '{2, 5}};
    for (int v = 0; v < 15; v++) begin
      press(0, vt[v].btn);
      outs(0, cur, mv, pf, go, bz);
      chk($sformatf("cursor vec %0d", v), cur, vt[v].exp_cur);
      chk($sformatf("moves vec %0d", v), mv, 0);
      cur_exp[0] = vt[v].exp_cur;
    end

    // Held move_x: initial step plus three repeats.
    @(negedge clk);
    mx_a = 1'b0;
    repeat (3 * RT + 2) @(negedge clk);
    mx_a = 1'b1;
    repeat (6) @(negedge clk);
    outs(0, cur, mv, pf, go, bz);
    chk("auto-repeat cursor", cur, 9);
    cur_exp[0] = 9;

    a = 0;
    b = -1;
    for (int j = 1; j < 20; j++)
      if (b < 0 && exp_pair[0][j] == exp_pair[0][a]) b = j;
    goto(0, a);
    press(0, 0);
    query(0, a, st, pr);
    chk("first flip face-up", st, 1);
    goto(0, b);
    press(0, 0);
    query(0, a, st, pr);
    chk("match card a", st, 2);
    query(0, b, st, pr);
    chk("match card b", st, 2);
    outs(0, cur, mv, pf, go, bz);
    chk("match pairs_found", pf, 1);
    chk("match moves", mv, 1);
    goto(0, a);
    press(0, 0);
    outs(0, cur, mv, pf, go, bz);
    chk("reselect moves", mv, 1);
    chk("reselect pairs_found", pf, 1);
    query(0, a, st, pr);
    chk("reselect card a", st, 2);
    query(0, b, st, pr);
    chk("reselect card b", st, 2);
    nfu = 0;
    for (int j = 0; j < 20; j++) begin
      query(0, j, st, pr);
      if (st == 1) nfu++;
    end
    chk("reselect face-up count", nfu, 0);

    c = (a == 0 && b == 1) ? 2 : ((a == 1 || b == 1) ? 0 : 1);
    if (c == a || c == b) c = 3;
    d = -1;
    e = -1;
    for (int j = 0; j < 20; j++) begin
      int ee;
      ee = (j / 5) * 5 + (j % 5 + 1) % 5;
      if (d < 0 && j != a && j != b && j != c &&
          exp_pair[0][j] != exp_pair[0][c] &&
          ee != a && ee != b && ee != c) begin
        d = j;
        e = ee;
      end
    end

    goto(0, c);
    press(0, 0);
    goto(0, d);
    qidx_a = 5'(d);
    @(negedge clk);
    sel_a = 1'b0;
    nup = 0;
    done = 0;
    for (int it = 1; it <= 150 && done == 0; it++) begin
      @(negedge clk);
      if (it == 3) sel_a = 1'b1;
      if (it == 6) mx_a = 1'b0;
      if (it == 9) mx_a = 1'b1;
      if (it == 14) sel_a = 1'b0;
      if (it == 17) sel_a = 1'b1;
      query(0, d, st, pr);
      if (st == 1) nup++;
      else if (nup > 0) done = 1;
    end
    chk("mismatch hold clocks", nup, MT + 1);
    cur_exp[0] = e;
    repeat (6) @(negedge clk);
    outs(0, cur, mv, pf, go, bz);
    chk("cursor moved in hold", cur, e);
    chk("mismatch moves", mv, 2);
    chk("mismatch pairs_found", pf, 1);
    chk("mismatch busy", bz, 0);
    query(0, c, st, pr);
    chk("mismatch card c down", st, 0);
    query(0, d, st, pr);
    chk("mismatch card d down", st, 0);
    query(0, e, st, pr);
    chk("select dropped in hold", st, 0);

    goto(0, c);
    press(0, 0);
    goto(0, d);
    press(0, 0);
    outs(0, cur, mv, pf, go, bz);
    chk("busy in mismatch hold", bz, 1);
    reset_dut(0);

    play_win(0, 10);
    for (int r = 0; r < 3; r++) begin
      restart(0);
      if (r < 2) play_win(0, 10);
    end

    reset_dut(1);
    play_win(1, 2);
    restart(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_game_core.md
# memory_game_core

Parametrised game engine for the card-matching VGA game. Owns the card grid state, the cursor, the pair-id shuffle, match/mismatch sequencing and score counters. Sits between the board buttons and the pixel renderer: the renderer reads any card's state and pair id through a combinational query port and draws it. It replaces the fixed 5×4, pulse-clocked logic with a single-clock, resettable engine of any even grid size. It adds a timed mismatch reveal, a move counter, auto-repeat cursor movement and in-place restart.

## Interface
- `COLS`, 5, grid columns (1..8)
- `ROWS`, 4, grid rows (1..8); `COLS*ROWS` must be even
- `REPEAT_TICKS`, 12_500_000, clocks between auto-repeat cursor steps while a move button is held
- `MISMATCH_TICKS`, 50_000_000, clocks a mismatched pair stays face-up
- `MOVE_W`, 10, width of the move counter

- `clock_50M` in 1 — single clock for everything
- `reset` in 1 — asynchronous, active-high
- `select` in 1 — active-low button, asynchronous to the clock
- `move_x` in 1 — active-low button; cursor column +1
- `move_y` in 1 — active-low button; cursor row +1
- `query_idx` in clog2(N) — card index, row-major (`row*COLS+col`), with `N=COLS*ROWS`
- `query_state` out 2 — FACE_DOWN=0, FACE_UP=1, MATCHED=2
- `query_pair` out clog2(N/2) — pair id of the queried card
- `cursor_idx` out clog2(N) — current cursor card
- `moves` out MOVE_W — completed two-card turns, saturating
- `pairs_found` out clog2(N/2)+1
- `game_over` out 1 — all pairs matched
- `busy` out 1 — high during SHUFFLE and SHOW_MISMATCH

## Operation
- **Buttons.** Each button passes through a 2-flop synchroniser, then a falling-edge detector, giving a one-cycle `press` pulse.
  - While a button stays low, a further `press` fires every REPEAT_TICKS clocks.
  - This auto-repeat applies to `move_x` and `move_y` only; `select` never repeats.
- **Cursor.**
  - `move_x` press: column = (column+1) mod COLS.
  - `move_y` press: row = (row+1) mod ROWS.
  - Cursor moves are accepted in every state.
- **LFSR.** 16-bit Fibonacci LFSR, taps 16,14,13,11, reset value 16'hACE1. It advances every clock and is never zero.
- **FSM states and transitions:**
  - **SHUFFLE**
    - First cycle: `pair[i]=i>>1` for all i; all cards FACE_DOWN; loop index `i=N-1`.
    - Each cycle: `k=(lfsr[7:0]*(i+1))>>8`, swap `pair[i]` with `pair[k]`, then `i--`.
    - When the cycle that handled `i=1` completes, go to NONE_UP. Total N-1 swap cycles.
  - **NONE_UP**
    - `select` press on a FACE_DOWN cursor card: that card becomes FACE_UP, record it as `first`, go to ONE_UP.
  - **ONE_UP**
    - `select` press on a FACE_DOWN card: that card becomes FACE_UP, record it as `second`, `moves++` (saturating), go to COMPARE.
  - **COMPARE** (one cycle)
    - Pair ids equal: both cards become MATCHED, `pairs_found++`. Go to WIN if `pairs_found` now equals N/2, else NONE_UP.
    - Pair ids differ: load the timer with MISMATCH_TICKS-1, go to SHOW_MISMATCH.
  - **SHOW_MISMATCH**
    - Timer decrements each clock. When it reaches 0, both cards return to FACE_DOWN and the FSM goes to NONE_UP.
    - `select` presses are dropped.
  - **WIN**
    - `game_over=1`.
    - `select` press: clear `moves` and `pairs_found`, go to SHUFFLE. The LFSR is not reset, so every game gets a fresh order.
- **Ignored inputs.** A `select` press on a FACE_UP or MATCHED card is ignored in every state.
- **Simultaneous events.** If `select` and a move press land in the same cycle, `select` acts on the pre-move cursor.

## Timing
- **Reset values:**
  - FSM enters SHUFFLE.
  - `cursor_idx=0`, `moves=0`, `pairs_found=0`, `game_over=0`, `busy=1`.
  - All cards FACE_DOWN; `pair[i]=i>>1`.
- **Reset mid-operation.** An asserted `reset` aborts any state, including SHUFFLE and SHOW_MISMATCH. After deassertion the engine reshuffles from seed 16'hACE1.
- **Button latency.** From a pin falling edge to the state/cursor update is 3–4 clocks: 2 synchroniser stages plus 1 edge stage, then the register update on the next edge.
- **Query port.** `query_*` is combinational from the registered card state, with zero latency, so the renderer may sweep `query_idx` every pixel.
- **Turn latency.** The second flip is visible in `query_state` one cycle before the COMPARE result.
- **Mismatch hold.** A mismatched pair stays FACE_UP for exactly MISMATCH_TICKS+1 clocks after the second flip.

## Structure
- Package `memory_game_pkg`:
  - `card_state_t` enum.
  - `game_state_t` enum {SHUFFLE, NONE_UP, ONE_UP, COMPARE, SHOW_MISMATCH, WIN}.
  - `LFSR_SEED`, `LFSR_TAPS`.
- Sub-module `button_conditioner`:
  - Synchroniser, falling-edge detector and optional auto-repeat (parameter `REPEAT_EN`).
  - Instantiated three times.
- Card state and pair ids are held in register arrays of depth N; no RAM.

## Test plan
- **Reset defaults.** COLS=5, ROWS=4: assert reset mid-SHOW_MISMATCH -> all outputs at reset values, all 20 cards FACE_DOWN, `busy` falls after 19 cycles.
- **Shuffle integrity.** After shuffle, sweep `query_idx` 0..19 -> each pair id 0..9 appears exactly twice. Repeat over 3 restarts -> the order differs each time.
- **Cursor wrap.** 5 `move_x` presses -> `cursor_idx` back to 0. 1 `move_y` + 2 `move_x` -> `cursor_idx=7`. Hold `move_x` for 3×REPEAT_TICKS -> exactly 4 steps.
- **Match.** Select two cards with equal pair id -> both MATCHED, `pairs_found=1`, `moves=1`. Reselecting either card leaves all state unchanged.
- **Mismatch.** Select two unequal cards -> both FACE_UP for MISMATCH_TICKS+1 clocks, then FACE_DOWN. A `select` press during the hold has no effect. `moves=1`.
- **Win and restart.** Match all pairs with COLS=2, ROWS=2 -> `game_over=1`, `pairs_found=2`. Then press `select` -> `moves=0`, `busy=1`, fresh shuffle.
